// File: rtl/xor_prng_checker.sv
// xor_prng_checker: receive-side checker for a 16-bit xorshift word stream.
// Seeds itself from the stream, locks after LOCK_COUNT correct predictions,
// then runs its own predictor and counts and flags mismatching words.
module xor_prng_checker #(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 3,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             valid,
    input  logic [15:0]      data,
    output logic             locked,
    output logic             error,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] word_count,
    output logic [1:0]       sync_state
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_C = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_C = 4'(LOSS_COUNT);

    // One xorshift step; every shift truncates to 16 bits, and 0 maps to 0.
    function automatic logic [15:0] prng_next(input logic [15:0] x);
        logic [15:0] t;
        logic [15:0] u;
        t = x ^ (x >> 7);
        u = t ^ (t << 9);
        return u ^ (u >> 8);
    endfunction

    state_t           state_q, state_d;
    logic [15:0]      pred_q, pred_d;
    logic [3:0]       match_cnt_q, match_cnt_d;
    logic [3:0]       miss_cnt_q, miss_cnt_d;
    logic             locked_q, locked_d;
    logic             error_q, error_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [CNT_W-1:0] word_count_q, word_count_d;

    logic [3:0]       match_inc;
    logic [3:0]       miss_inc;
    logic             hit;

    assign match_inc = match_cnt_q + 4'd1;
    assign miss_inc  = miss_cnt_q + 4'd1;
    assign hit       = (data == pred_q);

    // Next-state logic: sync FSM, predictor, error pulse and counters.
    always_comb begin
        state_d      = state_q;
        pred_d       = pred_q;
        match_cnt_d  = match_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        error_d      = 1'b0;
        err_count_d  = err_count_q;
        word_count_d = word_count_q;

        if (valid) begin
            unique case (state_q)
                SEARCH: begin
                    if (data != 16'h0000) begin
                        pred_d      = prng_next(data);
                        match_cnt_d = 4'd0;
                        state_d     = ACQUIRE;
                    end
                end
                ACQUIRE: begin
                    if (hit) begin
                        pred_d      = prng_next(data);
                        match_cnt_d = match_inc;
                        if (match_inc == LOCK_C) begin
                            state_d    = LOCKED;
                            miss_cnt_d = 4'd0;
                        end
                    end else if (data != 16'h0000) begin
                        pred_d      = prng_next(data);
                        match_cnt_d = 4'd0;
                    end else begin
                        state_d = SEARCH;
                    end
                end
                LOCKED: begin
                    // Flywheel: advance from our own prediction, never from data.
                    pred_d = prng_next(pred_q);
                    if (word_count_q != '1)
                        word_count_d = word_count_q + CNT_W'(1);
                    if (hit) begin
                        miss_cnt_d = 4'd0;
                    end else begin
                        error_d    = 1'b1;
                        miss_cnt_d = miss_inc;
                        if (err_count_q != '1)
                            err_count_d = err_count_q + CNT_W'(1);
                        if (miss_inc == LOSS_C) begin
                            state_d    = SEARCH;
                            miss_cnt_d = 4'd0;
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase
        end

        // Clear beats any same-cycle count; FSM and error are untouched.
        if (clear) begin
            err_count_d  = '0;
            word_count_d = '0;
        end

        locked_d = (state_d == LOCKED);
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SEARCH;
            pred_q       <= 16'h0000;
            match_cnt_q  <= 4'd0;
            miss_cnt_q   <= 4'd0;
            locked_q     <= 1'b0;
            error_q      <= 1'b0;
            err_count_q  <= '0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            pred_q       <= pred_d;
            match_cnt_q  <= match_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            locked_q     <= locked_d;
            error_q      <= error_d;
            err_count_q  <= err_count_d;
            word_count_q <= word_count_d;
        end
    end

    assign locked     = locked_q;
    assign error      = error_q;
    assign err_count  = err_count_q;
    assign word_count = word_count_q;
    assign sync_state = state_q;

endmodule

// File: tb/tb_xor_prng_checker.sv
// Directed bench for xor_prng_checker: a default build plus a CNT_W=4 build
// fed the same stimulus, so counter saturation can be reached quickly.
module tb_xor_prng_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        valid;
    logic [15:0] data;

    logic        locked, error;
    logic [15:0] err_count, word_count;
    logic [1:0]  sync_state;

    logic        locked4, error4;
    logic [3:0]  err_count4, word_count4;
    logic [1:0]  sync_state4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xor_prng_checker dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .valid(valid), .data(data),
        .locked(locked), .error(error), .err_count(err_count),
        .word_count(word_count), .sync_state(sync_state)
    );

    xor_prng_checker #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .valid(valid), .data(data),
        .locked(locked4), .error(error4), .err_count(err_count4),
        .word_count(word_count4), .sync_state(sync_state4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] nxt(input logic [15:0] x);
        logic [15:0] t, u;
        t = x ^ (x >> 7);
        u = t ^ (t << 9);
        return u ^ (u >> 8);
    endfunction

    function automatic logic [15:0] sk(input int k);
        logic [15:0] x;
        x = 16'h1ACE;
        for (int i = 0; i < k; i++) x = nxt(x);
        return x;
    endfunction

    // Present one cycle of input, then sample 1 ns after the accepting edge.
    task automatic send(input logic v, input logic [15:0] d, input logic c);
        @(negedge clk);
        valid = v;
        data  = d;
        clear = c;
        @(posedge clk);
        #1;
        valid = 1'b0;
        clear = 1'b0;
    endtask

    logic [15:0] x;
    logic [15:0] bad;

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        valid = 1'b0;
        data  = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_locked", locked, 0);
        chk("rst_error", error, 0);
        chk("rst_errcnt", err_count, 0);
        chk("rst_wordcnt", word_count, 0);
        chk("rst_state", sync_state, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Hand-computed first successor: next(16'h1ACE) = 16'hEC17.
        send(1, 16'h1ACE, 0);
        chk("seed_state", sync_state, 1);
        send(1, 16'hEC17, 0);
        chk("acq_s1_state", sync_state, 1);
        for (int k = 2; k <= 3; k++) begin
            send(1, sk(k), 0);
            chk("acq_unlocked", locked, 0);
        end
        send(1, sk(4), 0);
        chk("lock_s4", locked, 1);
        chk("lock_state", sync_state, 2);
        chk("lock_noerr", error, 0);
        chk("lock_wordcnt", word_count, 0);

        // S5..S20 with idle cycles in between.
        for (int k = 5; k <= 20; k++) begin
            send(1, sk(k), 0);
            chk("tog_locked", locked, 1);
            chk("tog_noerr", error, 0);
            send(0, 16'hDEAD, 0);
        end
        chk("tog_errcnt", err_count, 0);
        chk("tog_wordcnt", word_count, 16);

        // Single corrupted word; flywheel keeps the predictor on track.
        send(0, 16'h0000, 1);
        chk("clr_wordcnt", word_count, 0);
        chk("clr_locked", locked, 1);
        send(1, sk(21), 0);
        chk("fw_s21_err", error, 0);
        send(1, sk(22) ^ 16'h0001, 0);
        chk("fw_bad_err", error, 1);
        send(1, sk(23), 0);
        chk("fw_s23_err", error, 0);
        chk("fw_errcnt", err_count, 1);
        chk("fw_wordcnt", word_count, 3);
        chk("fw_locked", locked, 1);

        // Three consecutive misses drop lock.
        send(0, 16'h0000, 1);
        for (int i = 0; i < 3; i++) begin
            send(1, 16'h0000, 0);
            chk("loss_err", error, 1);
            chk("loss_locked", locked, (i < 2) ? 1 : 0);
        end
        chk("loss_state", sync_state, 0);
        chk("loss_errcnt", err_count, 3);
        chk("loss_wordcnt", word_count, 3);
        send(0, 16'h0000, 0);
        chk("loss_pulse_end", error, 0);
        send(1, sk(30), 0);
        chk("relock_seed", sync_state, 1);
        for (int k = 31; k <= 33; k++) begin
            send(1, sk(k), 0);
            chk("relock_wait", locked, 0);
        end
        send(1, sk(34), 0);
        chk("relock", locked, 1);

        // Asynchronous reset mid-stream.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_locked", locked, 0);
        chk("arst_state", sync_state, 0);
        chk("arst_errcnt", err_count, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero words never seed.
        for (int i = 0; i < 3; i++) begin
            send(1, 16'h0000, 0);
            chk("zero_state", sync_state, 0);
            chk("zero_err", error, 0);
        end
        send(1, sk(0), 0);
        chk("z_seed", sync_state, 1);
        bad = 16'h1234;
        send(1, bad, 0);
        chk("reseed_state", sync_state, 1);
        chk("reseed_err", error, 0);
        x = nxt(bad);
        for (int i = 1; i <= 4; i++) begin
            send(1, x, 0);
            chk("reseed_lock", locked, (i == 4) ? 1 : 0);
            x = nxt(x);
        end
        chk("reseed_wordcnt", word_count, 0);

        // Clear collides with a miscount: pulse still fires, counter reads 0.
        send(1, x ^ 16'hFFFF, 1);
        x = nxt(x);
        chk("clrhit_err", error, 1);
        chk("clrhit_errcnt", err_count, 0);
        chk("clrhit_wordcnt", word_count, 0);
        send(1, x, 0);
        x = nxt(x);
        chk("clrhit_next_err", error, 0);
        chk("clrhit_next_wc", word_count, 1);
        chk("clrhit_next_ec", err_count, 0);

        // Saturation of the 4-bit word counter.
        send(0, 16'h0000, 1);
        for (int i = 1; i <= 17; i++) begin
            send(1, x, 0);
            x = nxt(x);
            if (i == 14) chk("sat_wc4_14", word_count4, 14);
            if (i == 15) chk("sat_wc4_15", word_count4, 15);
        end
        chk("sat_wc4_hold", word_count4, 4'hF);
        chk("sat_wc16", word_count, 17);
        chk("sat_ec4", err_count4, 0);
        chk("sat_locked4", locked4, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xor_prng_checker.md
Name: xor_prng_checker

Overview:
- Receive-side checker for the 16-bit xorshift random stream used in the ray-sampling path.
- Self-synchronises to an incoming word stream by seeding from received words.
- Once locked, it free-runs its own predictor and flags mismatching words.
- Used in bring-up and BIST to confirm that PRNG outputs cross pipeline and clock-enable boundaries intact.

Parameters:
- LOCK_COUNT, 4: consecutive correct predictions needed to enter LOCKED; range 1..15.
- LOSS_COUNT, 3: consecutive mispredictions in LOCKED that force a return to SEARCH; range 1..15.
- CNT_W, 16: width of the error and word counters.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- clear, input, 1: synchronous clear of err_count and word_count; has no effect on the FSM.
- valid, input, 1: data carries a stream word this cycle.
- data, input, 16: received PRNG word.
- locked, output, 1: FSM is in LOCKED.
- error, output, 1: one-cycle pulse, the cycle after a mispredicted word is accepted in LOCKED.
- err_count, output, CNT_W: mispredicted words seen in LOCKED; saturating.
- word_count, output, CNT_W: words checked in LOCKED, both correct and incorrect; saturating.
- sync_state, output, 2: FSM encoding, SEARCH=0, ACQUIRE=1, LOCKED=2.

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-low (rst_n).
- Reset values: state SEARCH, pred 0, match_cnt 0, miss_cnt 0, locked 0, error 0, err_count 0, word_count 0.
- Step function, 16-bit, all shifts truncate to 16 bits:
  - t = x ^ (x>>7)
  - u = t ^ (u<<9), computed as u = t ^ (t<<9)
  - next(x) = u ^ (u>>8)
  - next(0)=0, so 0 is never a valid seed.
- All outputs are registered. Cycles with valid=0 change nothing, except that clear still acts.
- SEARCH:
  - valid with data!=0: pred<=next(data), match_cnt<=0, go to ACQUIRE.
  - valid with data==0: stay in SEARCH.
- ACQUIRE:
  - valid with data==pred: pred<=next(data), match_cnt<=match_cnt+1. If match_cnt+1==LOCK_COUNT, go to LOCKED with miss_cnt<=0.
  - valid with mismatch and data!=0: reseed with pred<=next(data), match_cnt<=0, stay in ACQUIRE.
  - valid with mismatch and data==0: go to SEARCH.
  - No error pulses and no counting happen in ACQUIRE.
- LOCKED (flywheel mode):
  - On every valid word: pred<=next(pred). The predictor is never reseeded from data, so corrupted words do not propagate.
  - word_count increments, saturating at all-ones.
  - Match: miss_cnt<=0.
  - Mismatch: error<=1 for one cycle, err_count increments (saturating), miss_cnt<=miss_cnt+1.
  - If miss_cnt+1==LOSS_COUNT: go to SEARCH, locked<=0 and miss_cnt<=0, on the same edge. That word still counts and still produces an error pulse.
- locked timing: rises on the edge that accepts the LOCK_COUNT-th correct word. locked is 1 in the cycle after that word is presented.
- Latency: error is 1 in the cycle after the offending valid word.
- clear:
  - clear together with a counting event: clear wins, and the counter reads 0 the next cycle.
  - clear does not touch the FSM, pred, locked or error.
- Saturation: at all-ones a counter holds; it never wraps.
- Reset mid-stream: everything returns to reset values immediately (asynchronous). After release, the checker needs a fresh seed word plus LOCK_COUNT correct words to lock again.

Test Plan:
Notation: S0=16'h1ACE, Sk=next(S(k-1)).
- Reset then S0..S4 on consecutive cycles: state goes SEARCH→ACQUIRE. locked=1 in the cycle after S4 (LOCK_COUNT=4); error stays 0.
- Lock, then S5..S20 with valid toggling 1/0: err_count=0 and word_count=16; locked stays 1 throughout.
- Locked; send S21, then S22^16'h0001 in place of S22, then S23: one error pulse the cycle after the bad word; err_count=1, word_count=3, still locked. This confirms the flywheel: S23 matches.
- Locked; send 3 consecutive wrong words (e.g. 16'h0000): 3 error pulses, err_count=3. locked falls in the cycle after the third word and sync_state=0. Resend S30..S34 and locked returns.
- Stream 16'h0000 repeatedly from reset: stays in SEARCH, locked=0, no errors. Then S0 followed by one bad word gives a reseed in ACQUIRE. Lock then needs 4 further correct successors of the bad word's reseed.
- Assert clear on the same cycle as a mismatched word in LOCKED: error pulses but err_count=0 next cycle. Separately, force word_count near all-ones (CNT_W=4 build) and confirm it saturates at 4'hF.
